// File: rtl/divider_share_pkg.sv
// divider_share_pkg
//   Shared definitions for the divider-sharing controller: the default
//   operand width, the controller state encoding and the response error codes.
package divider_share_pkg;

  localparam int DATA_W = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational round-robin picker. The winner is the first set bit of req
//   found searching upward from ptr+1 and wrapping around to ptr itself.
// Ports
//   req    in   N   request vector
//   ptr    in   IW  index of the previous winner
//   onehot out  N   one-hot winner (0 when no request)
//   idx    out  IW  winner index (0 when no request)
//   any    out  1   at least one request present
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Distance of each candidate from ptr+1 in wrap-around order; smallest wins.
  int best;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    best = N;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (((i + N - 1 - int'(ptr)) % N) < best)) begin
        best = (i + N - 1 - int'(ptr)) % N;
        idx  = IW'(i);
        any  = 1'b1;
      end
    end
  end

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = any && (idx == IW'(i));
    end
  end

endmodule

// File: rtl/divider_share_ctrl.sv
// divider_share_ctrl
//   Shares one sequential divider among N_REQ requesters. A round-robin winner
//   is granted in IDLE, its operands are captured, the divider is started with
//   a one-cycle pulse and the controller waits for div_done. Divide-by-zero is
//   answered directly without touching the divider. A watchdog aborts a divider
//   that never finishes and leaves the block in a sticky FAULT state.
//
//   Handshake: a requester raises req[i] with stable operands and holds it until
//   it sees rsp_valid with rsp_id == i; it must drop req[i] in the cycle after
//   rsp_valid, otherwise the still-high level is taken as a new request. gnt is
//   one-hot for the whole operation and returns to 0 after the response cycle.
//   Operands are sampled only in the grant cycle.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req                 level request per requester
//   req_dividend/divisor packed operands, requester i at [i*DATA_W +: DATA_W]
//   gnt                 one-hot owner of the current operation
//   rsp_valid           one-cycle response strobe with rsp_id/quotient/err
//   fault               sticky watchdog flag, cleared only by reset
//   div_start           one-cycle start pulse to the divider
//   div_dividend/divisor captured operands, stable for the whole operation
//   div_quotient/done   divider result; done is a level until the next start
//   dbg_state           current controller state
module divider_share_ctrl #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = divider_share_pkg::DATA_W,
  parameter int TIMEOUT = 64,
  localparam int IDW    = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_dividend,
  input  logic [N_REQ*DATA_W-1:0] req_divisor,
  output logic [N_REQ-1:0]        gnt,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic [DATA_W-1:0]       rsp_quotient,
  output logic [1:0]              rsp_err,
  output logic                    fault,
  output logic                    div_start,
  output logic [DATA_W-1:0]       div_dividend,
  output logic [DATA_W-1:0]       div_divisor,
  input  logic [DATA_W-1:0]       div_quotient,
  input  logic                    div_done,
  output logic [2:0]              dbg_state
);

  import divider_share_pkg::*;

  localparam int CW = $clog2(TIMEOUT);

  state_t            state, state_n;
  logic [IDW-1:0]    ptr, ptr_n;
  logic [N_REQ-1:0]  gnt_n;
  logic              rsp_valid_n;
  logic [IDW-1:0]    rsp_id_n;
  logic [DATA_W-1:0] rsp_quotient_n;
  logic [1:0]        rsp_err_n;
  logic              fault_n;
  logic              div_start_n;
  logic [DATA_W-1:0] dividend_n, divisor_n;
  logic [CW-1:0]     cnt, cnt_n;

  logic [N_REQ-1:0]  pick_onehot;
  logic [IDW-1:0]    pick_idx;
  logic              pick_any;
  logic [DATA_W-1:0] pick_dividend, pick_divisor;

  rr_pick #(.N(N_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Operand mux driven by the one-hot winner.
  always_comb begin
    pick_dividend = '0;
    pick_divisor  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_onehot[i]) begin
        pick_dividend = req_dividend[i*DATA_W +: DATA_W];
        pick_divisor  = req_divisor[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= IDW'(N_REQ - 1);
      gnt          <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_quotient <= '0;
      rsp_err      <= ERR_OK;
      fault        <= 1'b0;
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      cnt          <= '0;
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      gnt          <= gnt_n;
      rsp_valid    <= rsp_valid_n;
      rsp_id       <= rsp_id_n;
      rsp_quotient <= rsp_quotient_n;
      rsp_err      <= rsp_err_n;
      fault        <= fault_n;
      div_start    <= div_start_n;
      div_dividend <= dividend_n;
      div_divisor  <= divisor_n;
      cnt          <= cnt_n;
    end
  end

  always_comb begin
    state_n        = state;
    ptr_n          = ptr;
    gnt_n          = gnt;
    rsp_valid_n    = 1'b0;
    rsp_id_n       = rsp_id;
    rsp_quotient_n = rsp_quotient;
    rsp_err_n      = rsp_err;
    fault_n        = fault;
    div_start_n    = 1'b0;
    dividend_n     = div_dividend;
    divisor_n      = div_divisor;
    cnt_n          = cnt;

    case (state)
      IDLE: begin
        if (pick_any) begin
          gnt_n      = pick_onehot;
          ptr_n      = pick_idx;
          rsp_id_n   = pick_idx;
          dividend_n = pick_dividend;
          divisor_n  = pick_divisor;
          if (pick_divisor == '0) begin
            // Answered locally; the divider is never started.
            rsp_quotient_n = '1;
            rsp_err_n      = ERR_DIV0;
            rsp_valid_n    = 1'b1;
            state_n        = RESP;
          end else begin
            div_start_n = 1'b1;
            state_n     = ISSUE;
          end
        end
      end

      ISSUE: begin
        // div_done is still high from the previous operation here, so it is
        // not looked at until the divider has seen the start pulse.
        cnt_n   = '0;
        state_n = WAIT;
      end

      WAIT: begin
        if (div_done) begin
          rsp_quotient_n = div_quotient;
          rsp_err_n      = ERR_OK;
          rsp_valid_n    = 1'b1;
          state_n        = RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          rsp_quotient_n = '0;
          rsp_err_n      = ERR_TMO;
          rsp_valid_n    = 1'b1;
          fault_n        = 1'b1;
          state_n        = RESP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      RESP: begin
        gnt_n   = '0;
        state_n = fault ? FAULT : IDLE;
      end

      FAULT: begin
        gnt_n = '0;
      end

      default: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_divider_share_ctrl.sv
// tb_divider_share_ctrl
//   Bench for divider_share_ctrl with a behavioural divider stub (random
//   latency, optional hang) and a round-robin reference model.
module tb_divider_share_ctrl;

  localparam int N   = 4;
  localparam int W   = 24;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_dividend, req_divisor;
  logic [N-1:0]   gnt;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_quotient;
  logic [1:0]     rsp_err;
  logic           fault;
  logic           div_start;
  logic [W-1:0]   div_dividend, div_divisor;
  logic [W-1:0]   div_quotient;
  logic           div_done;
  logic [2:0]     dbg_state;

  always #5 clk = ~clk;

  divider_share_ctrl #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .gnt          (gnt),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_quotient (rsp_quotient),
    .rsp_err      (rsp_err),
    .fault        (fault),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .div_done     (div_done),
    .dbg_state    (dbg_state)
  );

  // Divider stub: done drops on start, rises after a random latency, stays high.
  logic         hang;
  logic         busy;
  int           lat;
  logic [W-1:0] sa, sb;

  always @(posedge clk) begin
    if (reset) begin
      div_done     <= 1'b0;
      div_quotient <= '0;
      busy         <= 1'b0;
      lat          <= 0;
    end else if (div_start) begin
      div_done <= 1'b0;
      busy     <= 1'b1;
      lat      <= int'($urandom_range(30, 20));
      sa       <= div_dividend;
      sb       <= div_divisor;
    end else if (busy && !hang) begin
      if (lat == 0) begin
        busy         <= 1'b0;
        div_done     <= 1'b1;
        div_quotient <= (sb == '0) ? '1 : sa / sb;
      end else begin
        lat <= lat - 1;
      end
    end
  end

  int start_cnt = 0;
  always @(posedge clk) if (div_start) start_cnt <= start_cnt + 1;

  // Checking helpers
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model
  logic [W-1:0] a_arr [N];
  logic [W-1:0] b_arr [N];
  int model_ptr;

  function automatic int rr_next(input logic [N-1:0] m);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (model_ptr + k) % N;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  task automatic pack_ops();
    for (int i = 0; i < N; i++) begin
      req_dividend[i*W +: W] = a_arr[i];
      req_divisor[i*W +: W]  = b_arr[i];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    model_ptr = N - 1;
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_gnt"}, 32'(gnt), 0);
    chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({pfx, "_rsp_id"}, 32'(rsp_id), 0);
    chk({pfx, "_rsp_quot"}, 32'(rsp_quotient), 0);
    chk({pfx, "_rsp_err"}, 32'(rsp_err), 0);
    chk({pfx, "_fault"}, 32'(fault), 0);
    chk({pfx, "_div_start"}, 32'(div_start), 0);
    chk({pfx, "_div_dividend"}, 32'(div_dividend), 0);
    chk({pfx, "_div_divisor"}, 32'(div_divisor), 0);
  endtask

  // Serve one operation for requester id; starts in an idle-side cycle.
  task automatic serve_one(input int id, input logic [N-1:0] drop_mask);
    logic [W-1:0] eq;
    logic [1:0]   ee;
    int           s0, gap;
    bit           got, seen_g;
    if (b_arr[id] == '0) begin eq = '1; ee = 2'b01; end
    else begin eq = a_arr[id] / b_arr[id]; ee = 2'b00; end
    s0 = start_cnt; got = 0; seen_g = 0; gap = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (seen_g) gap++;
      else if (gnt != '0) begin
        seen_g = 1;
        chk("gnt_onehot", 32'(gnt), 32'(1) << id);
      end
      if (rsp_valid) got = 1;
      else if (seen_g) begin
        // Operands changing after the grant must not affect the result.
        req_dividend[id*W +: W] = W'($urandom);
        req_divisor[id*W +: W]  = W'($urandom_range(1000, 1));
      end
    end
    chk("rsp_seen", 32'(got), 1);
    if (got) begin
      chk("rsp_id", 32'(rsp_id), id);
      chk("rsp_quot", 32'(rsp_quotient), 32'(eq));
      chk("rsp_err", 32'(rsp_err), 32'(ee));
      chk("rsp_gnt", 32'(gnt), 32'(1) << id);
      chk("start_pulses", start_cnt - s0, (b_arr[id] == '0) ? 0 : 1);
      if (b_arr[id] == '0) chk("div0_latency", gap, 0);
      else chk("div_operand_hold", 32'(div_dividend), 32'(a_arr[id]));
    end
    @(posedge clk); #1;
    req = req & ~drop_mask;
    pack_ops();
    @(negedge clk);
    chk("rsp_pulse_end", 32'(rsp_valid), 0);
    chk("gnt_cleared", 32'(gnt), 0);
  endtask

  // Raise all requesters in mask; each drops after its own response.
  task automatic run_mask(input logic [N-1:0] mask);
    logic [N-1:0] m;
    int w;
    m = mask;
    pack_ops();
    req = mask;
    while (m != '0) begin
      w = rr_next(m);
      serve_one(w, N'(1) << w);
      m[w] = 1'b0;
      model_ptr = w;
    end
  endtask

  initial begin
    logic [N-1:0] mask;
    int  gap, bad, w;
    bit  got, seen;

    reset = 1'b1; req = '0; hang = 1'b0;
    for (int i = 0; i < N; i++) begin a_arr[i] = '0; b_arr[i] = 24'd1; end
    pack_ops();
    model_ptr = N - 1;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single requester 0: 100/7
    a_arr[0] = 24'd100; b_arr[0] = 24'd7;
    run_mask(4'b0001);

    // Two simultaneous requesters: 40/8 and 81/9
    a_arr[1] = 24'd40; b_arr[1] = 24'd8;
    a_arr[2] = 24'd81; b_arr[2] = 24'd9;
    run_mask(4'b0110);

    // All four requesting continuously for 8 operations after reset
    do_reset();
    for (int i = 0; i < N; i++) begin a_arr[i] = W'(1000 * (i + 1) + 7); b_arr[i] = W'(i + 3); end
    pack_ops();
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      w = rr_next(4'b1111);
      chk("cont_order", w, k % N);
      serve_one(w, (k == 7) ? 4'b1111 : 4'b0000);
      model_ptr = w;
    end

    // Divide by zero on requester 3
    a_arr[3] = 24'd12345; b_arr[3] = 24'd0;
    run_mask(4'b1000);

    // Randomized rounds
    for (int r = 0; r < 10; r++) begin
      mask = N'($urandom_range(15, 1));
      for (int i = 0; i < N; i++) begin
        a_arr[i] = W'($urandom);
        case ($urandom_range(3, 0))
          0:       b_arr[i] = '0;
          1:       b_arr[i] = W'($urandom_range(300, 1));
          2:       b_arr[i] = W'($urandom) | 24'd1;
          default: b_arr[i] = a_arr[i] | 24'd1;
        endcase
      end
      run_mask(mask);
    end

    // Watchdog: divider never completes
    hang = 1'b1;
    a_arr[0] = 24'd50; b_arr[0] = 24'd5;
    pack_ops();
    req = 4'b0001;
    got = 0; seen = 0; gap = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (seen) gap++;
      else if (gnt != '0) seen = 1;
      if (rsp_valid) got = 1;
    end
    chk("tmo_rsp_seen", 32'(got), 1);
    chk("tmo_latency", gap, TMO + 1);
    chk("tmo_err", 32'(rsp_err), 2);
    chk("tmo_id", 32'(rsp_id), 0);
    chk("tmo_fault", 32'(fault), 1);
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    chk("tmo_gnt_cleared", 32'(gnt), 0);
    req = 4'b1111;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (gnt != '0 || rsp_valid || div_start || !fault) bad++;
    end
    chk("fault_blocks_reqs", bad, 0);
    hang = 1'b0;
    do_reset();
    @(negedge clk);
    chk("fault_cleared", 32'(fault), 0);

    // Reset in the middle of WAIT
    a_arr[0] = 24'd100; b_arr[0] = 24'd7;
    pack_ops();
    req = 4'b0001;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (gnt != '0) seen = 1;
    end
    chk("mid_gnt_seen", 32'(seen), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    chk_zero_outputs("midreset");
    reset = 1'b0;
    model_ptr = N - 1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid || gnt != '0) bad++;
    end
    chk("no_rsp_after_reset", bad, 0);
    a_arr[0] = 24'd9;    b_arr[0] = 24'd3;
    a_arr[2] = 24'd1000; b_arr[2] = 24'd10;
    run_mask(4'b0101);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
